demux1_4_reg: RTL and testbench
===============================

# demux1_4_reg

Registered 1-to-4 demultiplexer with valid/ready handshakes: the inverse of the 4-to-1 select path. A single input stream is steered to one of four output lanes (a, b, c, d). The lane is chosen either by an explicit select or by an internal round-robin pointer. It sits on the fan-out side of the datapath, feeding four independent consumers that may stall individually.

## Interface
- WIDTH, 8, data width of input and every output lane
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  input word
- in_valid  input  1  input word present
- in_ready  output  1  block accepts in_data this cycle
- s0  input  1  lane select bit 0 (explicit mode)
- s1  input  1  lane select bit 1 (explicit mode)
- rr_mode  input  1  1 = round-robin steering, 0 = explicit s1:s0 steering
- out_a, out_b, out_c, out_d  output  WIDTH  lane data registers
- valid_a, valid_b, valid_c, valid_d  output  1  lane holds a word
- ready_a, ready_b, ready_c, ready_d  input  1  consumer takes lane word this cycle
- rr_ptr  output  2  current round-robin target lane
- drop_cnt  output  8  count of cycles with in_valid=1 and in_ready=0, saturating at 255

## Operation
- Lane map, identical in both modes: 00→a, 01→b, 10→c, 11→d. Index = {s1,s0} in explicit mode, rr_ptr in round-robin mode.
- Target lane tgt = rr_mode ? rr_ptr : {s1,s0}. The choice is combinational in the current cycle.
- Each lane is a one-entry register with a valid flag.
- Lane drain: valid_x && ready_x. On drain, valid_x clears at the next edge unless the lane is refilled in the same cycle.
- in_ready = !valid_tgt || (valid_tgt && ready_tgt). This allows full throughput: one word per cycle into a continuously drained lane.
- Accept: in_valid && in_ready. At the next edge, out_tgt ← in_data and valid_tgt ← 1. Non-target lanes are untouched apart from their own drains.
- Lane data registers change only on accept. Data persists after drain; consumers must qualify with valid.
- rr_ptr advances +1 mod 4 (3→0 wraps) only on an accept while rr_mode=1. It holds otherwise, including across rr_mode toggles.
- rr_mode=1 with the target lane full and not draining: in_ready=0 and the pointer does not skip to another lane. Ordering across lanes is strict.
- drop_cnt increments on every cycle with in_valid && !in_ready and saturates at 255.
- Reset, synchronous, at a clk edge with rst=1:
  - valid_a..valid_d = 0
  - out_a..out_d = 0
  - rr_ptr = 0
  - drop_cnt = 0
  - in_ready reads 1 the cycle after reset.
- Reset mid-operation discards all held lane words and does not complete pending handshakes. An accept coinciding with rst=1 is lost.

## Timing
- Latency: input accepted at edge N is visible on out_x with valid_x=1 after edge N (one cycle).
- in_ready is combinational from rr_mode, s1, s0, rr_ptr, lane valids and ready_tgt. There is no combinational path from in_data to any output.
- Simultaneous drain and refill of the same lane: the new word is loaded and valid stays 1. The consumer saw the old word at the drain edge.
- Simultaneous accept on lane x and drain on lane y≠x: both take effect at the same edge.
- Changing s1:s0 or rr_mode while in_valid=1 and in_ready=0 is legal. The transfer is re-evaluated every cycle against the current target.
- rr_ptr update and lane load occur on the same edge.

## Test plan
- Reset, then explicit mode, ready_*=1, in_data=0x11/0x22/0x33/0x44 with s1:s0=00/01/10/11 on consecutive cycles → out_a=0x11, out_b=0x22, out_c=0x33, out_d=0x44, each valid for exactly one cycle, one cycle after its accept; drop_cnt=0.
- Explicit mode, s1:s0=10, ready_c=0, three valid words 0xA0, 0xA1, 0xA2 → 0xA0 is held in out_c and in_ready=0 for the next two cycles with drop_cnt=2. Raising ready_c drains 0xA0 and accepts 0xA1 on the same edge, with valid_c staying 1.
- Round-robin, all ready=1, eight back-to-back words 0..7 → lanes a,b,c,d,a,b,c,d receive 0..7 in order; rr_ptr returns to 0 after the eighth accept (wrap check).
- Round-robin, ready_b=0 with lane b full, rr_ptr=1 → in_ready=0 and rr_ptr stays 1, with no skip to c. Releasing ready_b resumes with a refill of b, then rr_ptr=2.
- Hold in_valid=1 with in_ready=0 for 300 cycles → drop_cnt saturates at 255 with no wrap.
- Lanes a and c full, rr_ptr=2; assert rst for one cycle → next cycle all valids 0, rr_ptr=0, drop_cnt=0, in_ready=1. A word presented during the rst=1 cycle does not appear on any lane.

Source files
------------

// File: rtl/demux1_4_reg_if.sv
// Handshake/bus bundle for the registered 1-to-4 demultiplexer.
//
// Purpose: groups the input stream, steering controls, the four output lanes
// and the status outputs so the block and its producer/consumers share one
// connection point.
//
// Signals:
//   in_data, in_valid, in_ready : input word stream (valid/ready handshake)
//   s0, s1, rr_mode             : lane steering (explicit {s1,s0} or round-robin)
//   out_a..out_d, valid_a..d    : per-lane data register and occupancy flag
//   ready_a..ready_d            : per-lane consumer acceptance
//   rr_ptr                      : current round-robin target lane
//   drop_cnt                    : saturating count of stalled input cycles
//
// Modports:
//   slave  : the demultiplexer itself
//   master : the environment (producer plus the four consumers)
interface demux1_4_reg_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             s0;
  logic             s1;
  logic             rr_mode;

  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic             valid_a;
  logic             valid_b;
  logic             valid_c;
  logic             valid_d;
  logic             ready_a;
  logic             ready_b;
  logic             ready_c;
  logic             ready_d;

  logic [1:0]       rr_ptr;
  logic [7:0]       drop_cnt;

  modport slave (
    input  in_data, in_valid, s0, s1, rr_mode,
    input  ready_a, ready_b, ready_c, ready_d,
    output in_ready,
    output out_a, out_b, out_c, out_d,
    output valid_a, valid_b, valid_c, valid_d,
    output rr_ptr, drop_cnt
  );

  modport master (
    output in_data, in_valid, s0, s1, rr_mode,
    output ready_a, ready_b, ready_c, ready_d,
    input  in_ready,
    input  out_a, out_b, out_c, out_d,
    input  valid_a, valid_b, valid_c, valid_d,
    input  rr_ptr, drop_cnt
  );

endinterface

// File: rtl/demux1_4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes.
//
// Purpose: steers a single input stream into one of four one-entry lane
// registers (a, b, c, d). The target lane is {s1,s0} in explicit mode or an
// internal round-robin pointer in round-robin mode. Each lane drains
// independently through its own ready; a lane may be drained and refilled on
// the same edge, giving one word per cycle into a continuously drained lane.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (clears lanes, pointer, drop count)
//   bus  : demux1_4_reg_if.slave bundle (stream, steering, lanes, status)
module demux1_4_reg #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  demux1_4_reg_if.slave  bus
);

  logic [WIDTH-1:0] lane_data [4];
  logic [3:0]       lane_valid;
  logic [3:0]       lane_ready;
  logic [3:0]       lane_drain;
  logic [3:0]       lane_load;
  logic [1:0]       tgt;
  logic [1:0]       rr_ptr_q;
  logic [7:0]       drop_cnt_q;
  logic             in_ready_c;
  logic             accept;

  // Target selection and handshake. The round-robin pointer never skips a
  // stalled lane, so a full, non-draining target simply blocks the input.
  always_comb begin
    lane_ready = {bus.ready_d, bus.ready_c, bus.ready_b, bus.ready_a};
    lane_drain = lane_valid & lane_ready;
    tgt        = bus.rr_mode ? rr_ptr_q : {bus.s1, bus.s0};
    in_ready_c = !lane_valid[tgt] || lane_drain[tgt];
    accept     = bus.in_valid && in_ready_c;
    lane_load  = 4'b0000;
    if (accept) begin
      lane_load[tgt] = 1'b1;
    end
  end

  // Lane registers, pointer and drop counter. A load wins over a drain on the
  // same lane so the valid flag stays high across a back-to-back refill.
  // Lane data only changes on a load; it is left in place after a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        lane_data[i] <= '0;
      end
      lane_valid <= 4'b0000;
      rr_ptr_q   <= 2'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_load[i]) begin
          lane_data[i]  <= bus.in_data;
          lane_valid[i] <= 1'b1;
        end else if (lane_drain[i]) begin
          lane_valid[i] <= 1'b0;
        end
      end
      if (accept && bus.rr_mode) begin
        rr_ptr_q <= rr_ptr_q + 2'd1;
      end
      if (bus.in_valid && !in_ready_c && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.out_a    = lane_data[0];
  assign bus.out_b    = lane_data[1];
  assign bus.out_c    = lane_data[2];
  assign bus.out_d    = lane_data[3];
  assign bus.valid_a  = lane_valid[0];
  assign bus.valid_b  = lane_valid[1];
  assign bus.valid_c  = lane_valid[2];
  assign bus.valid_d  = lane_valid[3];
  assign bus.rr_ptr   = rr_ptr_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux1_4_reg.sv
// Testbench for demux1_4_reg.
//
// Purpose: drives directed words into the demultiplexer and checks lane
// contents, handshake status, round-robin pointer and drop counter. Each
// issued word pushes its hand-computed (lane, data) pair into a scoreboard;
// a monitor pops and compares whenever a lane hands a word to its consumer.
module tb_demux1_4_reg;

  typedef struct {
    int         lane;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  exp_t exp_q[$];

  logic [7:0] mon_data [4];
  logic [3:0] valid_vec;
  logic [3:0] ready_vec;

  demux1_4_reg_if #(.WIDTH(8)) bus ();

  demux1_4_reg #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign mon_data[0] = bus.out_a;
  assign mon_data[1] = bus.out_b;
  assign mon_data[2] = bus.out_c;
  assign mon_data[3] = bus.out_d;
  assign valid_vec   = {bus.valid_d, bus.valid_c, bus.valid_b, bus.valid_a};
  assign ready_vec   = {bus.ready_d, bus.ready_c, bus.ready_b, bus.ready_a};

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one word, wait (bounded) for the handshake, record the expected
  // lane/data pair, then drop in_valid one time step after the accepting edge.
  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] sel,
                               input logic rr, input int exp_lane);
    exp_t e;
    bit   got;
    bus.in_data  = data;
    bus.s1       = sel[1];
    bus.s0       = sel[0];
    bus.rr_mode  = rr;
    bus.in_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got    = 1'b1;
        e.lane = exp_lane;
        e.data = data;
        exp_q.push_back(e);
      end
    end
    if (!got) begin
      total_cnt++;
      $display("[TB] FAIL accept_timeout: word 0x%0h never accepted, expected lane %0d", data, exp_lane);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setReady(input logic [3:0] r);
    bus.ready_a = r[0];
    bus.ready_b = r[1];
    bus.ready_c = r[2];
    bus.ready_d = r[3];
  endtask

  // Monitor: a lane with valid and ready hands its word over at the next
  // edge, so compare it against the oldest expected word for that lane.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (valid_vec[i] && ready_vec[i]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (idx < 0 && exp_q[j].lane == i) idx = j;
          end
          if (idx < 0) begin
            total_cnt++;
            $display("[TB] FAIL unexpected_word lane %0d: got 0x%0h, expected no word", i, mon_data[i]);
          end else begin
            checkOutput($sformatf("lane%0d_data", i), int'(mon_data[i]), int'(exp_q[idx].data));
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst          = 1'b1;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.s0       = 1'b0;
    bus.s1       = 1'b0;
    bus.rr_mode  = 1'b0;
    setReady(4'b1111);
    tick(2);
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_valids",   int'(valid_vec),    0);
    checkOutput("rst_rr_ptr",   int'(bus.rr_ptr),   0);
    checkOutput("rst_drop_cnt", int'(bus.drop_cnt), 0);
    checkOutput("rst_in_ready", int'(bus.in_ready), 1);
    checkOutput("rst_out_a",    int'(bus.out_a),    0);
    tick(1);

    // Explicit steering, all consumers ready, back-to-back words.
    applyStimulus(8'h11, 2'b00, 1'b0, 0);
    applyStimulus(8'h22, 2'b01, 1'b0, 1);
    applyStimulus(8'h33, 2'b10, 1'b0, 2);
    applyStimulus(8'h44, 2'b11, 1'b0, 3);
    @(negedge clk);
    checkOutput("expl_only_d_valid", int'(valid_vec), 4'b1000);
    checkOutput("expl_out_d",        int'(bus.out_d), 8'h44);
    tick(1);
    @(negedge clk);
    checkOutput("expl_all_drained", int'(valid_vec),    0);
    checkOutput("expl_a_persists",  int'(bus.out_a),    8'h11);
    checkOutput("expl_drop_cnt",    int'(bus.drop_cnt), 0);
    tick(1);

    // Lane c stalled: A0 held, A1 blocked for two cycles, then drain+refill.
    setReady(4'b1011);
    applyStimulus(8'hA0, 2'b10, 1'b0, 2);
    bus.in_data  = 8'hA1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("stall_in_ready_1", int'(bus.in_ready), 0);
    checkOutput("stall_out_c",      int'(bus.out_c),    8'hA0);
    tick(1);
    @(negedge clk);
    checkOutput("stall_in_ready_2", int'(bus.in_ready), 0);
    tick(1);
    setReady(4'b1111);
    @(negedge clk);
    begin
      exp_t e;
      e.lane = 2;
      e.data = 8'hA1;
      checkOutput("stall_drop_cnt",     int'(bus.drop_cnt), 2);
      checkOutput("refill_in_ready",    int'(bus.in_ready), 1);
      exp_q.push_back(e);
    end
    tick(1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("refill_valid_c", int'(bus.valid_c), 1);
    checkOutput("refill_out_c",   int'(bus.out_c),   8'hA1);
    tick(1);
    applyStimulus(8'hA2, 2'b10, 1'b0, 2);
    tick(1);

    // Round-robin over eight words; select pins are deliberately ignored.
    for (int w = 0; w < 8; w++) begin
      applyStimulus(8'(w), 2'b11, 1'b1, w % 4);
    end
    @(negedge clk);
    checkOutput("rr_wrap_ptr", int'(bus.rr_ptr), 0);
    tick(1);

    // Round-robin with lane b stalled: no skip past b.
    setReady(4'b1101);
    applyStimulus(8'h30, 2'b00, 1'b1, 0);
    applyStimulus(8'h31, 2'b00, 1'b1, 1);
    applyStimulus(8'h32, 2'b00, 1'b1, 2);
    applyStimulus(8'h33, 2'b00, 1'b1, 3);
    applyStimulus(8'h34, 2'b00, 1'b1, 0);
    bus.in_data  = 8'h35;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("rr_block_in_ready", int'(bus.in_ready), 0);
    checkOutput("rr_block_ptr",      int'(bus.rr_ptr),   1);
    tick(1);
    @(negedge clk);
    checkOutput("rr_no_skip_c", int'(bus.valid_c), 0);
    tick(1);
    setReady(4'b1111);
    @(negedge clk);
    begin
      exp_t e;
      e.lane = 1;
      e.data = 8'h35;
      exp_q.push_back(e);
    end
    tick(1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rr_resume_ptr",   int'(bus.rr_ptr),   2);
    checkOutput("rr_resume_out_b", int'(bus.out_b),    8'h35);
    checkOutput("rr_drop_cnt",     int'(bus.drop_cnt), 4);
    tick(2);
    checkOutput("scoreboard_drained_1", exp_q.size(), 0);

    // Drop counter saturation: 300 stalled cycles on a full lane a.
    setReady(4'b1110);
    applyStimulus(8'h50, 2'b00, 1'b0, 0);
    bus.in_data  = 8'h51;
    bus.in_valid = 1'b1;
    tick(300);
    @(negedge clk);
    checkOutput("sat_drop_cnt",  int'(bus.drop_cnt), 255);
    checkOutput("sat_in_ready",  int'(bus.in_ready), 0);
    tick(1);
    bus.in_valid = 1'b0;

    // Reset with lanes a and c full and rr_ptr at 2; a word offered to the
    // empty lane b during the reset cycle must be lost.
    setReady(4'b1010);
    applyStimulus(8'h60, 2'b10, 1'b0, 2);
    @(negedge clk);
    checkOutput("prerst_valids", int'(valid_vec),  4'b0101);
    checkOutput("prerst_rr_ptr", int'(bus.rr_ptr), 2);
    tick(1);
    rst          = 1'b1;
    bus.in_data  = 8'hEE;
    bus.s1       = 1'b0;
    bus.s0       = 1'b1;
    bus.rr_mode  = 1'b0;
    bus.in_valid = 1'b1;
    tick(1);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    setReady(4'b1111);
    @(negedge clk);
    checkOutput("midrst_valids",   int'(valid_vec),    0);
    checkOutput("midrst_rr_ptr",   int'(bus.rr_ptr),   0);
    checkOutput("midrst_drop_cnt", int'(bus.drop_cnt), 0);
    checkOutput("midrst_in_ready", int'(bus.in_ready), 1);
    checkOutput("midrst_out_b",    int'(bus.out_b),    0);
    tick(1);
    applyStimulus(8'h77, 2'b11, 1'b0, 3);
    tick(2);
    checkOutput("scoreboard_drained_2", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
